// File: rtl/trace_pkg.sv
// Shared encodings for the trace capture unit: FSM states, capture modes
// and the layout of one stored trace entry.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    localparam logic [1:0] MODE_CONT = 2'd0;
    localparam logic [1:0] MODE_FILL = 2'd1;
    localparam logic [1:0] MODE_TRIG = 2'd2;

    // One entry packs {pc, inst, debug}, pc in the most significant field.
    localparam int ENTRY_FIELDS = 3;

    function automatic int entryWidth(input int xlen);
        return ENTRY_FIELDS * xlen;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: register array with one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 96
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the incoming entry on every enabled clock edge.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/trace_buffer.sv
// Per-cycle trace recorder: captures (pc, inst, debug) tuples into a
// circular buffer in continuous, fill-once or PC-triggered mode, then
// drains them oldest-first through a valid/ready port.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 16,
    parameter int POST_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic [1:0]               i_mode,
    input  logic [XLEN-1:0]          i_trig_pc,
    input  logic [POST_W-1:0]        i_post_cnt,
    input  logic                     i_valid,
    input  logic [XLEN-1:0]          i_pc,
    input  logic [XLEN-1:0]          i_inst,
    input  logic [XLEN-1:0]          i_debug,
    input  logic                     i_rd_ready,
    output logic                     o_rd_valid,
    output logic [XLEN-1:0]          o_rd_pc,
    output logic [XLEN-1:0]          o_rd_inst,
    output logic [XLEN-1:0]          o_rd_debug,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_triggered,
    output logic                     o_done,
    output logic [1:0]               o_state
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = entryWidth(XLEN);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_FREE = CNT_W'(DEPTH - 1);

    state_e              state_q,     state_d;
    logic [PTR_W-1:0]    wrPtr_q,     wrPtr_d;
    logic [PTR_W-1:0]    rdPtr_q,     rdPtr_d;
    logic [CNT_W-1:0]    count_q,     count_d;
    logic [POST_W-1:0]   remaining_q, remaining_d;
    logic                triggered_q, triggered_d;
    logic [1:0]          mode_q,      mode_d;
    logic [XLEN-1:0]     trigPc_q,    trigPc_d;
    logic [POST_W-1:0]   postCnt_q,   postCnt_d;

    logic                wrEn;
    logic                rdFire;
    logic                rdValid;
    logic [ENTRY_W-1:0]  ramRdata;

    assign wrEn    = ((state_q == ST_CAPTURE) || (state_q == ST_POST)) && i_valid;
    assign rdValid = (state_q == ST_DRAIN) && (count_q != '0);
    assign rdFire  = rdValid && i_rd_ready;

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (wrEn),
        .i_waddr (wrPtr_q),
        .i_wdata ({i_pc, i_inst, i_debug}),
        .i_raddr (rdPtr_q),
        .o_rdata (ramRdata)
    );

    // Next-state logic: session setup, write/overwrite bookkeeping, trigger and drain.
    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        triggered_d = triggered_q;
        mode_d      = mode_q;
        trigPc_d    = trigPc_q;
        postCnt_d   = postCnt_q;

        case (state_q)
            ST_IDLE: begin
                if (i_en) begin
                    state_d     = ST_CAPTURE;
                    wrPtr_d     = '0;
                    rdPtr_d     = '0;
                    count_d     = '0;
                    remaining_d = '0;
                    triggered_d = 1'b0;
                    mode_d      = (i_mode == 2'd3) ? MODE_CONT : i_mode;
                    trigPc_d    = i_trig_pc;
                    postCnt_d   = i_post_cnt;
                end
            end
            ST_CAPTURE, ST_POST: begin
                if (wrEn) begin
                    wrPtr_d = wrPtr_q + PTR_W'(1);
                    if (count_q == FULL_CNT) begin
                        rdPtr_d = rdPtr_q + PTR_W'(1);
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (state_q == ST_CAPTURE) begin
                        if ((mode_q == MODE_FILL) && (count_q == LAST_FREE)) begin
                            state_d = ST_DRAIN;
                        end
                        if ((mode_q == MODE_TRIG) && (i_pc == trigPc_q)) begin
                            triggered_d = 1'b1;
                            if (postCnt_q == '0) begin
                                state_d = ST_DRAIN;
                            end else begin
                                state_d     = ST_POST;
                                remaining_d = postCnt_q;
                            end
                        end
                    end else begin
                        remaining_d = remaining_q - POST_W'(1);
                        if (remaining_q == POST_W'(1)) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                if (!i_en) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (rdFire) begin
                    rdPtr_d = rdPtr_q + PTR_W'(1);
                    count_d = count_q - CNT_W'(1);
                end else if ((count_q == '0) && !i_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous reset that aborts any session.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            triggered_q <= 1'b0;
            mode_q      <= MODE_CONT;
            trigPc_q    <= '0;
            postCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            triggered_q <= triggered_d;
            mode_q      <= mode_d;
            trigPc_q    <= trigPc_d;
            postCnt_q   <= postCnt_d;
        end
    end

    assign o_rd_valid  = rdValid;
    assign o_rd_pc     = rdValid ? ramRdata[3*XLEN-1:2*XLEN] : '0;
    assign o_rd_inst   = rdValid ? ramRdata[2*XLEN-1:XLEN]   : '0;
    assign o_rd_debug  = rdValid ? ramRdata[XLEN-1:0]        : '0;
    assign o_count     = count_q;
    assign o_triggered = triggered_q;
    assign o_done      = (state_q == ST_DRAIN);
    assign o_state     = state_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Self-checking bench for trace_buffer: a behavioural model keeps the
// expected buffer contents in a queue that is filled as samples are driven
// and popped as the DUT drains entries.
module tb_trace_buffer;
    import trace_pkg::*;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 16;
    localparam int POST_W = 8;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_en;
    logic [1:0]        i_mode;
    logic [XLEN-1:0]   i_trig_pc;
    logic [POST_W-1:0] i_post_cnt;
    logic              i_valid;
    logic [XLEN-1:0]   i_pc;
    logic [XLEN-1:0]   i_inst;
    logic [XLEN-1:0]   i_debug;
    logic              i_rd_ready;
    logic              o_rd_valid;
    logic [XLEN-1:0]   o_rd_pc;
    logic [XLEN-1:0]   o_rd_inst;
    logic [XLEN-1:0]   o_rd_debug;
    logic [$clog2(DEPTH):0] o_count;
    logic              o_triggered;
    logic              o_done;
    logic [1:0]        o_state;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state.
    logic [XLEN-1:0]   sb[$];
    state_e            mState;
    logic              mTrig;
    logic [1:0]        mMode;
    logic [XLEN-1:0]   mTrigPc;
    logic [POST_W-1:0] mPost;
    logic [POST_W-1:0] mRem;

    trace_buffer #(
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .POST_W (POST_W)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_mode      (i_mode),
        .i_trig_pc   (i_trig_pc),
        .i_post_cnt  (i_post_cnt),
        .i_valid     (i_valid),
        .i_pc        (i_pc),
        .i_inst      (i_inst),
        .i_debug     (i_debug),
        .i_rd_ready  (i_rd_ready),
        .o_rd_valid  (o_rd_valid),
        .o_rd_pc     (o_rd_pc),
        .o_rd_inst   (o_rd_inst),
        .o_rd_debug  (o_rd_debug),
        .o_count     (o_count),
        .o_triggered (o_triggered),
        .o_done      (o_done),
        .o_state     (o_state)
    );

    // Free-running clock.
    always #5 i_clk = ~i_clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [XLEN-1:0] instOf(input logic [XLEN-1:0] pc);
        return ~pc;
    endfunction

    function automatic logic [XLEN-1:0] debugOf(input logic [XLEN-1:0] pc);
        return pc + 32'h1000_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [XLEN-1:0] pc);
        i_valid = valid;
        i_pc    = pc;
        i_inst  = instOf(pc);
        i_debug = debugOf(pc);
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic modelEdge();
        state_e nxt;
        nxt = mState;
        case (mState)
            ST_IDLE: begin
                if (i_en) begin
                    nxt = ST_CAPTURE;
                    sb.delete();
                    mTrig   = 1'b0;
                    mMode   = (i_mode == 2'd3) ? MODE_CONT : i_mode;
                    mTrigPc = i_trig_pc;
                    mPost   = i_post_cnt;
                end
            end
            ST_CAPTURE, ST_POST: begin
                if (i_valid) begin
                    sb.push_back(i_pc);
                    if (sb.size() > DEPTH) void'(sb.pop_front());
                    if (mState == ST_CAPTURE) begin
                        if (mMode == MODE_FILL && sb.size() == DEPTH) nxt = ST_DRAIN;
                        if (mMode == MODE_TRIG && i_pc == mTrigPc) begin
                            mTrig = 1'b1;
                            if (mPost == 0) nxt = ST_DRAIN;
                            else begin
                                nxt  = ST_POST;
                                mRem = mPost;
                            end
                        end
                    end else begin
                        mRem = mRem - 1'b1;
                        if (mRem == 0) nxt = ST_DRAIN;
                    end
                end
                if (!i_en) nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (sb.size() != 0 && i_rd_ready) void'(sb.pop_front());
                else if (sb.size() == 0 && !i_en) nxt = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
        mState = nxt;
    endtask

    // Check the read port, clock once, then check state and occupancy.
    task automatic stepCycle();
        #1;
        if (mState == ST_DRAIN) begin
            checkOutput("rdValid", 32'(o_rd_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                checkOutput("rdPc", o_rd_pc, sb[0]);
                checkOutput("rdInst", o_rd_inst, instOf(sb[0]));
                checkOutput("rdDebug", o_rd_debug, debugOf(sb[0]));
            end else begin
                checkOutput("rdPcEmpty", o_rd_pc, 32'h0);
            end
        end else begin
            checkOutput("rdValidOutsideDrain", 32'(o_rd_valid), 32'h0);
        end
        modelEdge();
        @(posedge i_clk);
        #1;
        checkOutput("state", 32'(o_state), 32'(mState));
        checkOutput("count", 32'(o_count), 32'(sb.size()));
        checkOutput("triggered", 32'(o_triggered), 32'(mTrig));
        checkOutput("done", 32'(o_done), 32'(mState == ST_DRAIN));
    endtask

    task automatic doReset();
        i_rst      = 1'b1;
        i_en       = 1'b0;
        i_rd_ready = 1'b0;
        applyStimulus(1'b0, 32'h0);
        @(posedge i_clk);
        #1;
        i_rst  = 1'b0;
        mState = ST_IDLE;
        mTrig  = 1'b0;
        mRem   = '0;
        sb.delete();
        checkOutput("rstState", 32'(o_state), 32'h0);
        checkOutput("rstCount", 32'(o_count), 32'h0);
        checkOutput("rstTriggered", 32'(o_triggered), 32'h0);
        checkOutput("rstDone", 32'(o_done), 32'h0);
        checkOutput("rstRdValid", 32'(o_rd_valid), 32'h0);
        checkOutput("rstRdPc", o_rd_pc, 32'h0);
    endtask

    task automatic startSession(input logic [1:0] mode, input logic [XLEN-1:0] trigPc, input logic [POST_W-1:0] postCnt);
        i_en       = 1'b1;
        i_mode     = mode;
        i_trig_pc  = trigPc;
        i_post_cnt = postCnt;
        i_rd_ready = 1'b0;
        applyStimulus(1'b1, 32'hFFFF_FFF0);
        stepCycle();
    endtask

    // Drive n valid samples pc=0,4,8,...; with gaps, an invalid cycle carrying
    // the trigger PC follows every valid one.
    task automatic runSamples(input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1, 32'(k * 4));
            stepCycle();
            if (gaps) begin
                applyStimulus(1'b0, 32'h40);
                stepCycle();
            end
        end
    endtask

    task automatic drainAll(input bit toggleReady);
        i_en = 1'b0;
        applyStimulus(1'b0, 32'h0);
        for (int c = 0; c < 200 && mState != ST_IDLE; c++) begin
            i_rd_ready = toggleReady ? (c[0] == 1'b0) : 1'b1;
            stepCycle();
        end
        checkOutput("drainToIdle", 32'(o_state), 32'(ST_IDLE));
    endtask

    initial begin
        i_rst      = 1'b0;
        i_en       = 1'b0;
        i_mode     = 2'd0;
        i_trig_pc  = '0;
        i_post_cnt = '0;
        i_rd_ready = 1'b0;
        applyStimulus(1'b0, 32'h0);
        mState  = ST_IDLE;
        mTrig   = 1'b0;
        mMode   = MODE_CONT;
        mTrigPc = '0;
        mPost   = '0;
        mRem    = '0;

        doReset();

        $display("[TB] fill-once capture");
        startSession(MODE_FILL, 32'h0, 8'd0);
        runSamples(20, 1'b0);
        drainAll(1'b0);

        $display("[TB] continuous capture with overwrite and ignored mid-session mode change");
        startSession(MODE_CONT, 32'h0, 8'd0);
        i_mode    = MODE_FILL;
        i_trig_pc = 32'h8;
        runSamples(20, 1'b0);
        drainAll(1'b0);

        $display("[TB] trigger with post window of 3, backpressured drain");
        startSession(MODE_TRIG, 32'h40, 8'd3);
        runSamples(20, 1'b0);
        drainAll(1'b1);

        $display("[TB] trigger with zero post window");
        startSession(MODE_TRIG, 32'h40, 8'd0);
        runSamples(20, 1'b0);
        drainAll(1'b0);

        $display("[TB] trigger with gaps in valid");
        startSession(MODE_TRIG, 32'h40, 8'd3);
        runSamples(20, 1'b1);
        drainAll(1'b1);

        $display("[TB] reserved mode acts as continuous");
        startSession(2'd3, 32'h0, 8'd0);
        runSamples(3, 1'b0);
        drainAll(1'b0);

        $display("[TB] reset during post window, then fresh session");
        startSession(MODE_TRIG, 32'h40, 8'd8);
        runSamples(19, 1'b0);
        checkOutput("inPost", 32'(o_state), 32'(ST_POST));
        doReset();
        startSession(MODE_CONT, 32'h0, 8'd0);
        runSamples(5, 1'b0);
        drainAll(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/trace_buffer.md
Name: trace_buffer

Overview:
- Synthesizable per-cycle trace capture unit for the nano core. It records (pc, inst, debug) tuples into a parametrised circular buffer.
- It replaces the bench-side per-cycle print loop with an on-chip recorder.
- Three capture modes: continuous, fill-once, and PC-triggered with a post-trigger window.
- Captured entries are drained oldest-first through a valid/ready read port.

Parameters:
- XLEN, 32, width of pc, inst and debug fields.
- DEPTH, 16, number of entries; power of two, at least 2.
- POST_W, 8, width of the post-trigger count.
- CNT_W, derived as $clog2(DEPTH)+1 (localparam, not overridable), occupancy counter width.

Ports:
- i_clk  in  1  single clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  arm capture; deassert to end capture or to release from DRAIN.
- i_mode  in  2  0=CONT, 1=FILL, 2=TRIG; 3 is reserved and behaves as CONT.
- i_trig_pc  in  XLEN  trigger PC compare value (TRIG mode).
- i_post_cnt  in  POST_W  number of valid samples recorded after the trigger entry.
- i_valid  in  1  sample qualifier (one retired instruction).
- i_pc  in  XLEN  sample program counter.
- i_inst  in  XLEN  sample instruction word.
- i_debug  in  XLEN  sample debug word.
- i_rd_ready  in  1  consumer accepts the head entry.
- o_rd_valid  out  1  head entry available.
- o_rd_pc  out  XLEN  head entry pc field.
- o_rd_inst  out  XLEN  head entry inst field.
- o_rd_debug  out  XLEN  head entry debug field.
- o_count  out  CNT_W  current occupancy, 0..DEPTH.
- o_triggered  out  1  trigger seen in the current session.
- o_done  out  1  capture finished (state is DRAIN).
- o_state  out  2  0=IDLE, 1=CAPTURE, 2=POST, 3=DRAIN.

Behaviour:
- Reset, on the cycle after i_rst is high: state IDLE, write pointer, read pointer, count and post counter = 0, o_triggered=0. Every output is 0. RAM contents are not cleared.
- Reset mid-operation, in any state, aborts the session identically.
- IDLE -> CAPTURE on i_en=1:
  - Pointers, count and o_triggered are cleared.
  - i_mode, i_trig_pc and i_post_cnt are latched; mid-session changes to them are ignored.
  - No sample is written in the transition cycle.
- CAPTURE write rule: each cycle with i_valid=1, the tuple is written at wr_ptr and wr_ptr increments modulo DEPTH. The entry is visible in o_count on the next cycle (1-cycle latency).
- Full in CONT, TRIG or POST: overwrite the oldest entry. wr_ptr and rd_ptr both advance; count stays DEPTH.
- Full in FILL: on the write that makes count=DEPTH, go to DRAIN. Nothing is ever overwritten.
- CONT: stays in CAPTURE until i_en=0, then goes to DRAIN. A sample with i_valid=1 in that same cycle is still written.
- TRIG, trigger firing:
  - When i_valid=1 and i_pc==latched trig_pc, the entry is written and o_triggered=1.
  - If latched post_cnt=0, go to DRAIN; otherwise go to POST with remaining=post_cnt.
- POST: each valid write decrements remaining. The write that takes remaining from 1 to 0 goes to DRAIN. No further trigger matching occurs.
- i_en=0 in CAPTURE or POST, any mode: go to DRAIN. o_triggered keeps its value.
- DRAIN:
  - No writes; o_done=1.
  - o_rd_valid = (count != 0). o_rd_* show mem[rd_ptr] combinationally and are 0 when o_rd_valid=0.
  - o_rd_valid & i_rd_ready pops the head: rd_ptr+1 mod DEPTH, count-1. Data is held stable while ready is low.
- DRAIN -> IDLE when count=0 and i_en=0. If i_en is still high, the block waits in DRAIN.
- o_rd_valid is always 0 outside DRAIN.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. Count saturates at DEPTH and never exceeds it.

Decomposition:
- Package trace_pkg holds:
  - the state encoding (IDLE/CAPTURE/POST/DRAIN as 2-bit constants);
  - the mode constants MODE_CONT=0, MODE_FILL=1, MODE_TRIG=2;
  - the entry width constant 3*XLEN.
- One sub-module, trace_ram: DEPTH x (3*XLEN) register array with one synchronous write port and one asynchronous read port. No reset on the storage.
- FSM, pointers, counters and trigger compare live in trace_buffer.

Test Plan:
- FILL, DEPTH=16: 20 valid samples, pc=0,4,8,... -> DRAIN after the 16th sample, count=16. Drain yields pc 0x00..0x3C in order, then o_rd_valid=0.
- CONT: 20 valid samples, then i_en=0 -> count=16. Drain yields pc 0x10..0x4C, so the oldest 4 are overwritten.
- TRIG, trig_pc=0x40, post_cnt=3, same pc stream -> o_triggered at pc 0x40; DRAIN after pc 0x4C is written. Drain yields pc 0x10..0x4C. A second run with post_cnt=0 stops immediately after pc 0x40.
- i_valid gaps: alternate i_valid 1/0 in TRIG with post_cnt=3 -> exactly 3 post entries are recorded. Invalid cycles never write and never decrement.
- Backpressure: toggle i_rd_ready 1/0 during drain -> each entry is popped exactly once, o_rd_* are stable while ready=0, and count decrements only on handshake.
- Reset in POST: pulse i_rst for 1 cycle -> next cycle o_state=0, o_count=0, o_triggered=0, o_done=0, o_rd_valid=0. A fresh session then captures correctly.
